// File: rtl/dcm_sp.sv
// Behavioural model of a spartan-style clock manager: measures the CLKIN period
// and synthesizes phase-shifted, doubled, divided and fractional clocks from it.
`timescale 1ns/1ps
module dcm_sp #(
    parameter int    CLKFX_MULTIPLY = 4,
    parameter int    CLKFX_DIVIDE   = 1,
    parameter int    CLKDV_DIVIDE   = 2,
    parameter real   CLKIN_PERIOD   = 10.0,
    parameter string CLK_FEEDBACK   = "1X"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkfb,
    output logic       clk0,
    output logic       clk90,
    output logic       clk180,
    output logic       clk270,
    output logic       clk2x,
    output logic       clkdv,
    output logic       clkfx,
    output logic       clkfx180,
    output logic       locked,
    output logic [7:0] status
);

    int      epoch;
    int      acc;
    int      dv_cnt;
    int      fx_cnt;
    int      rise_cnt;
    int      fb_cnt;
    bit      have_edge;
    bit      have_meas;
    bit      stop_flag;
    bit      fb_flag;
    realtime last_rise;
    real     prev;
    real     tin;

    initial begin
        if (CLKFX_MULTIPLY < 2 || CLKFX_MULTIPLY > 32 ||
            CLKFX_DIVIDE < 1 || CLKFX_DIVIDE > 32 ||
            CLKDV_DIVIDE < 2 || CLKDV_DIVIDE > 16 ||
            CLKIN_PERIOD < 5.0 || CLKIN_PERIOD > 200.0 ||
            (CLK_FEEDBACK != "1X" && CLK_FEEDBACK != "NONE")) begin
            $display("dcm_sp %m: illegal parameter value");
            $finish;
        end
    end

    assign clk0     = clk & locked;
    assign clkfx180 = locked & ~clkfx;
    assign status   = {5'b0, fb_flag, stop_flag, 1'b0};

    always @(posedge clkfb) fb_cnt <= fb_cnt + 1;

    // Bumping epoch orphans every pending timed edge, so outputs drop at once.
    task automatic kill();
        epoch  = epoch + 1;
        locked = 1'b0;
        clk90  = 1'b0;
        clk180 = 1'b0;
        clk270 = 1'b0;
        clk2x  = 1'b0;
        clkdv  = 1'b0;
        clkfx  = 1'b0;
    endtask

    task automatic launch();
        int  e        = epoch;
        real t        = tin;
        real tfx      = tin * CLKFX_DIVIDE / CLKFX_MULTIPLY;
        int  rc       = rise_cnt;
        int  fc       = fb_cnt;
        bit  dv_start = (dv_cnt == 0);
        bit  fx_start = (fx_cnt == 0);
        dv_cnt = (dv_cnt + 1) % CLKDV_DIVIDE;
        fx_cnt = (fx_cnt + 1) % CLKFX_DIVIDE;
        clk2x  = 1'b1;
        if (dv_start) clkdv = 1'b1;
        fork
            begin
                #(t/4); if (e == epoch) clk2x = 1'b0;
                #(t/4); if (e == epoch) clk2x = 1'b1;
                #(t/4); if (e == epoch) clk2x = 1'b0;
            end
            begin #(t/4);   if (e == epoch) clk90  = 1'b1; #(t/2); if (e == epoch) clk90  = 1'b0; end
            begin #(t/2);   if (e == epoch) clk180 = 1'b1; #(t/2); if (e == epoch) clk180 = 1'b0; end
            begin #(3*t/4); if (e == epoch) clk270 = 1'b1; #(t/2); if (e == epoch) clk270 = 1'b0; end
            begin
                if (dv_start) begin
                    #(CLKDV_DIVIDE * t / 2);
                    if (e == epoch) clkdv = 1'b0;
                end
            end
            // One burst of M pulses per D input periods keeps clkfx aligned to clk.
            begin
                if (fx_start) begin
                    for (int i = 0; i < CLKFX_MULTIPLY; i++) begin
                        if (e == epoch) clkfx = 1'b1;
                        #(tfx/2);
                        if (e == epoch) clkfx = 1'b0;
                        #(tfx/2);
                    end
                end
            end
            begin
                #(2*t);
                if (e == epoch && rise_cnt == rc) begin
                    stop_flag = 1'b1;
                    acc       = 0;
                    kill();
                end
            end
            begin
                if (CLK_FEEDBACK == "1X") begin
                    #(2*t);
                    if (e == epoch && fb_cnt == fc) fb_flag = 1'b1;
                end
            end
        join_none
    endtask

    task automatic on_rise();
        realtime now = $realtime;
        real     p;
        bit      ok;
        rise_cnt = rise_cnt + 1;
        if (!have_edge) begin
            have_edge = 1'b1;
            last_rise = now;
        end else begin
            p         = now - last_rise;
            last_rise = now;
            ok        = !have_meas || ((p > prev ? p - prev : prev - p) <= 0.01 * prev);
            prev      = p;
            have_meas = 1'b1;
            if (ok) begin
                if (acc < 3) acc = acc + 1;
                tin = p;
                if (!locked && acc == 3) begin
                    locked = 1'b1;
                    dv_cnt = 0;
                    fx_cnt = 0;
                end
                if (locked) launch();
            end else begin
                acc = 0;
                if (locked) kill();
            end
        end
    endtask

    always begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            kill();
            have_edge = 1'b0;
            have_meas = 1'b0;
            acc       = 0;
            stop_flag = 1'b0;
            fb_flag   = 1'b0;
        end else begin
            on_rise();
        end
    end

endmodule

// File: tb/tb_dcm_sp.sv
// Randomized-period bench for dcm_sp: a queue of clk rise times drives a
// reference model of lock acquisition and of each output waveform.
`timescale 1ns/1ps
module tb_dcm_sp;

    logic clk, reset, clk_run;
    real  per;
    realtime rises[$];

    logic clk0_a, clk90_a, clk180_a, clk270_a, clk2x_a, clkdv_a, clkfx_a, clkfx180_a, locked_a;
    logic clk0_b, clk90_b, clk180_b, clk270_b, clk2x_b, clkdv_b, clkfx_b, clkfx180_b, locked_b;
    logic [7:0] status_a, status_b, out_a, out_b;
    int n_vec, n_err, cfx_a, cfx_b;

    dcm_sp #(.CLKFX_MULTIPLY(4), .CLKFX_DIVIDE(1), .CLKDV_DIVIDE(2),
             .CLKIN_PERIOD(10.0), .CLK_FEEDBACK("1X")) dut_a (
        .clk(clk), .reset(reset), .clkfb(1'b0),
        .clk0(clk0_a), .clk90(clk90_a), .clk180(clk180_a), .clk270(clk270_a),
        .clk2x(clk2x_a), .clkdv(clkdv_a), .clkfx(clkfx_a), .clkfx180(clkfx180_a),
        .locked(locked_a), .status(status_a));

    dcm_sp #(.CLKFX_MULTIPLY(5), .CLKFX_DIVIDE(3), .CLKDV_DIVIDE(3),
             .CLKIN_PERIOD(10.0), .CLK_FEEDBACK("1X")) dut_b (
        .clk(clk), .reset(reset), .clkfb(clk0_b),
        .clk0(clk0_b), .clk90(clk90_b), .clk180(clk180_b), .clk270(clk270_b),
        .clk2x(clk2x_b), .clkdv(clkdv_b), .clkfx(clkfx_b), .clkfx180(clkfx180_b),
        .locked(locked_b), .status(status_b));

    assign out_a = {clkfx180_a, clkfx_a, clkdv_a, clk2x_a, clk270_a, clk180_a, clk90_a, clk0_a};
    assign out_b = {clkfx180_b, clkfx_b, clkdv_b, clk2x_b, clk270_b, clk180_b, clk90_b, clk0_b};

    always @(posedge clkfx_a) cfx_a <= cfx_a + 1;
    always @(posedge clkfx_b) cfx_b <= cfx_b + 1;

    // Each period length is latched at its rising edge, so per changes apply cleanly.
    initial begin
        real cur;
        clk = 1'b0;
        forever begin
            if (!clk_run) wait (clk_run);
            clk = 1'b1;
            rises.push_back($realtime);
            cur = per;
            #(cur/2);
            clk = 1'b0;
            #(cur/2);
        end
    end

    initial begin
        #60000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $realtime);
        end
    endtask

    // Lock rule over the rise history: 3 consecutive periods each within 1% of the last.
    task automatic model_lock(output bit lk, output int li);
        int  acc = 0;
        real m, pm = 0.0;
        lk = 1'b0;
        li = -1;
        for (int i = 1; i < rises.size(); i++) begin
            m = rises[i] - rises[i-1];
            if (i == 1 || ((m > pm ? m - pm : pm - m) <= 0.01 * pm)) begin
                acc++;
                if (!lk && acc >= 3) begin lk = 1'b1; li = i; end
            end else begin
                acc = 0;
                lk  = 1'b0;
            end
            pm = m;
        end
    endtask

    function automatic logic [7:0] wave(input real x, input real t, input int k,
                                        input int m, input int d, input int dv);
        logic [7:0] w;
        real y, tfx;
        w[0] = x < t/2;
        w[1] = x >= t/4 && x < 3*t/4;
        w[2] = x >= t/2;
        w[3] = x >= 3*t/4 || (x < t/4 && k > 0);
        w[4] = x < t/4 || (x >= t/2 && x < 3*t/4);
        y    = (k % dv) * t + x;
        w[5] = y < dv * t / 2;
        tfx  = d * t / m;
        y    = (k % d) * t + x;
        y    = y - tfx * $floor(y / tfx);
        w[6] = y < tfx/2;
        w[7] = !w[6];
        return w;
    endfunction

    task automatic sample();
        bit lk;
        int li, n, k;
        real t, x;
        logic [7:0] e, lo, hi, mask;
        model_lock(lk, li);
        chk("lock_a", {31'b0, locked_a}, {31'b0, lk});
        chk("lock_b", {31'b0, locked_b}, {31'b0, lk});
        if (!lk) begin
            chk("idle_a", {24'b0, out_a}, 32'b0);
            chk("idle_b", {24'b0, out_b}, 32'b0);
        end else begin
            n = rises.size();
            t = rises[n-1] - rises[n-2];
            k = n - 1 - li;
            x = $realtime - rises[n-1];
            e = wave(x, t, k, 4, 1, 2); lo = wave(x-0.02, t, k, 4, 1, 2); hi = wave(x+0.02, t, k, 4, 1, 2);
            mask = ~(lo ^ e) & ~(hi ^ e);
            chk("wave_a", {24'b0, out_a & mask}, {24'b0, e & mask});
            e = wave(x, t, k, 5, 3, 3); lo = wave(x-0.02, t, k, 5, 3, 3); hi = wave(x+0.02, t, k, 5, 3, 3);
            mask = ~(lo ^ e) & ~(hi ^ e);
            chk("wave_b", {24'b0, out_b & mask}, {24'b0, e & mask});
        end
    endtask

    task automatic rises_check(input int n);
        bit lk;
        int li;
        repeat (n) begin
            @(posedge clk);
            #0.1;
            model_lock(lk, li);
            chk("rise_lock_a", {31'b0, locked_a}, {31'b0, lk});
            chk("rise_lock_b", {31'b0, locked_b}, {31'b0, lk});
        end
    endtask

    task automatic run_samples(input int n);
        repeat (n) begin
            @(posedge clk);
            #(0.05 + (per - 0.1) * $urandom_range(0, 1000) / 1000.0);
            sample();
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_a"}, {15'b0, locked_a, status_a, out_a}, 32'b0);
        chk({tag, "_b"}, {15'b0, locked_b, status_b, out_b}, 32'b0);
    endtask

    initial begin
        bit lk;
        int li, c_a, c_b;
        reset = 1'b0; clk_run = 1'b0; per = 10.0;
        #1;
        check_cleared("reset_state");
        #1 reset = 1'b1;
        rises.delete();
        #1 clk_run = 1'b1;

        // 10 ns clock: lock on the 4th rise, feedback watchdog, fx edge counts
        rises_check(4);
        chk("lock_at_4th", {30'b0, locked_a, locked_b}, 32'h3);
        #(2*per - 1.1);
        chk("fb_quiet", {16'b0, status_a, status_b}, 32'h0);
        #2;
        chk("fb_stopped", {16'b0, status_a, status_b}, 32'h0400);
        chk("fb_keeps_lock", {31'b0, locked_a}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #0.1;
            model_lock(lk, li);
            if ((rises.size() - 1 - li) % 3 == 0) break;
        end
        c_a = cfx_a; c_b = cfx_b;
        #(3*per);
        chk("fx_edges_a", cfx_a - c_a, 12);
        chk("fx_edges_b", cfx_b - c_b, 5);
        run_samples(30);

        // 7 ns reset pulses mid-lock, then reacquire at a random period
        for (int it = 0; it < 4; it++) begin
            @(posedge clk);
            #0.5 reset = 1'b0;
            #0.1;
            check_cleared("rst_pulse");
            per = 0.4 * $urandom_range(20, 40);
            #6.9 reset = 1'b1;
            rises.delete();
            rises_check(4);
            chk("relock_4th", {30'b0, locked_a, locked_b}, 32'h3);
            #(2*per - 1.1);
            chk("fb_quiet_r", {24'b0, status_a}, 32'h0);
            #2;
            chk("fb_stopped_r", {24'b0, status_a}, 32'h04);
            run_samples(12);
        end

        // back to 10 ns, then a single 10.5 ns period knocks lock loose
        @(posedge clk);
        #0.5 per = 10.0;
        rises_check(6);
        run_samples(5);
        @(posedge clk);
        #0.5 per = 10.5;
        @(posedge clk);
        #0.1 chk("pre_glitch", {31'b0, locked_a}, 32'h1);
        @(posedge clk);
        #0.1;
        chk("glitch_drop", {22'b0, locked_a, locked_b, out_a}, 32'h0);
        chk("glitch_out_b", {24'b0, out_b}, 32'h0);
        @(posedge clk);
        #0.1 chk("reacq_1", {31'b0, locked_a}, 32'h0);
        @(posedge clk);
        #0.1 chk("reacq_2", {31'b0, locked_a}, 32'h0);
        @(posedge clk);
        #0.1 chk("reacq_3", {30'b0, locked_a, locked_b}, 32'h3);
        run_samples(8);

        // clk stops: stop flag within 2 periods, sticky until reset
        @(posedge clk);
        #0.1 clk_run = 1'b0;
        #(2*per - 1.1);
        chk("stop_early", {30'b0, locked_a, status_a[1]}, 32'h2);
        #2;
        chk("stop_a", {23'b0, locked_a, status_a}, 32'h06);
        chk("stop_b", {23'b0, locked_b, status_b}, 32'h02);
        chk("stop_out", {16'b0, out_a, out_b}, 32'h0);
        per = 10.0;
        clk_run = 1'b1;
        rises_check(7);
        chk("stop_sticky", {30'b0, status_a[1], status_b[1]}, 32'h3);
        run_samples(5);
        #0.3 reset = 1'b0;
        #0.1;
        check_cleared("final_reset");
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcm_sp.md
DCM_SP -- requirements
Module: dcm_sp

Interface
REQ-001 Parameter CLKFX_MULTIPLY, default 4, integer M multiplier for clkfx; legal range 2..32.
REQ-002 Parameter CLKFX_DIVIDE, default 1, integer D divider for clkfx; legal range 1..32.
REQ-003 Parameter CLKDV_DIVIDE, default 2, integer divider for clkdv; legal range 2..16.
REQ-004 Parameter CLKIN_PERIOD, default 10.0, nominal input period in ns; used only for the range check.
REQ-005 Parameter CLK_FEEDBACK, default "1X", string; "1X" or "NONE"; selects whether clkfb is monitored.
REQ-006 Port clk, input, 1: CLKIN reference clock; the module's only clock.
REQ-007 Port reset, input, 1: asynchronous, active-low reset; the block is in reset while reset=0.
REQ-008 Port clkfb, input, 1: feedback clock, normally clk0 returned through a global buffer.
REQ-009 Ports clk0, clk90, clk180, clk270, output, 1 each: 1x clock at 0/90/180/270 degrees.
REQ-010 Ports clk2x, clkdv, clkfx, clkfx180, output, 1 each: 2x, divided, synthesized and inverted synthesized clocks.
REQ-011 Port locked, output, 1: all outputs valid and phase-aligned.
REQ-012 Port status, output, 8: bit1 = clk stopped; bit2 = clkfb stopped; all other bits 0.

Function
REQ-013 SHALL be a behavioral simulation model; output timing derives from the measured clk period Tin, using real time.
REQ-014 SHALL measure Tin between consecutive clk rising edges.
REQ-015 SHALL accept a measurement that is within ±1% of the previous measurement.
REQ-016 SHALL assert locked on the rising edge that completes 3 consecutive accepted measurements, which is the 4th clk rising edge after reset release.
REQ-017 All clock outputs SHALL start toggling at the same instant locked asserts.
REQ-018 Before lock, all clock outputs SHALL be held 0.
REQ-019 clk0 SHALL be a zero-delay copy of clk, with ideal deskew and duty cycle.
REQ-020 clk90, clk180 and clk270 SHALL be clk0 delayed by Tin/4, Tin/2 and 3Tin/4 respectively.
REQ-021 clk2x SHALL have period Tin/2 and 50% duty, with a rising edge on every clk rising edge.
REQ-022 clkdv SHALL have period CLKDV_DIVIDE×Tin and 50% duty, rising on the lock edge and on every CLKDV_DIVIDE-th clk rise after it.
REQ-023 clkfx SHALL have period Tin×D/M and 50% duty, emitting exactly M rising edges per D input periods.
REQ-024 clkfx SHALL realign its rising edge to a clk rising edge every D input periods.
REQ-025 clkfx180 SHALL be the inverse of clkfx.
REQ-026 While locked, a period measurement outside ±1% SHALL deassert locked and force clock outputs to 0 at that edge, then restart acquisition per REQ-016.
REQ-027 While locked, if no clk rising edge arrives within 2×Tin, status[1] SHALL be set to 1, locked cleared and outputs forced to 0.
REQ-028 After a REQ-027 stop, status[1] SHALL stay 1 until reset.
REQ-029 With CLK_FEEDBACK="1X", if clkfb shows no rising edge within 2×Tin while locked, status[2] SHALL be set to 1; locked is unaffected.
REQ-030 With CLK_FEEDBACK="NONE", clkfb SHALL be ignored and status[2] SHALL stay 0.
REQ-031 An illegal parameter value, or CLKIN_PERIOD outside 5.0..200.0, SHALL produce a $display error and $finish at time 0.

Reset
REQ-032 reset=0 SHALL asynchronously force all clock outputs, locked and status to 0.
REQ-033 reset=0 SHALL discard all period measurements.
REQ-034 Reset asserted mid-lock SHALL take effect at the same simulation time, with no completion of the current output pulses.
REQ-035 After reset returns to 1, acquisition SHALL restart per REQ-016.

Verification
REQ-036 clk 10 ns, M=4, D=1, CLKDV_DIVIDE=2, reset released at 0 ns -> locked rises at the 4th clk rise; clkfx period 2.5 ns; clk2x period 5 ns; clkdv period 20 ns; clk90 rises 2.5 ns after clk0.
REQ-037 clk 10 ns, M=5, D=3 -> clkfx period 6 ns; clkfx rise coincides with a clk rise every 30 ns; 5 clkfx rises per 30 ns.
REQ-038 Locked, then reset=0 for 7 ns -> all outputs and locked are 0 immediately; after release, locked re-asserts at the 4th clk rise.
REQ-039 Locked, then clk held low -> status[1]=1 and locked=0 by 20 ns after the last clk rise.
REQ-040 Locked at 10 ns, then one 10.5 ns period -> locked drops at that edge; locked re-asserts after 3 matching 10.5 ns measurements.
REQ-041 CLK_FEEDBACK="1X" with clkfb tied 0 -> status[2]=1 within 20 ns of lock; locked stays 1.
